// File: rtl/pc_fetch_unit.sv
// Instruction fetch stage: PC register, instruction-memory request, IF/ID pipeline
// register with a one-entry skid buffer for a fetch that completes under stall.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] pc_out,
    input  logic [31:0] pc_plus4,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        ifid_valid,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4,
    output logic        fetch_err
);

    // state | meaning
    // IDLE  | post-reset settle cycle, no request, redirect ignored
    // FETCH | request outstanding at pc, one instruction per acked cycle
    // HOLD  | fetched word parked in skid buffer until stall drops
    // ERR   | misaligned redirect seen, frozen until reset
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_ERR   = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [31:0] pc;
    logic [31:0] pc_nxt;
    logic        ifid_valid_nxt;
    logic [31:0] ifid_instr_nxt;
    logic [31:0] ifid_pc4_nxt;
    logic        fetch_err_nxt;

    logic [31:0] skid_instr;
    logic [31:0] skid_instr_nxt;
    logic [31:0] skid_pc4;
    logic [31:0] skid_pc4_nxt;
    logic        skid_valid;
    logic        skid_valid_nxt;

    logic        redir_active;
    logic        redir_misaligned;

    assign pc_out    = pc;
    assign imem_addr = pc;
    assign imem_req  = (state == S_FETCH);

    assign redir_active     = redirect && ((state == S_FETCH) || (state == S_HOLD));
    assign redir_misaligned = (redirect_pc[1:0] != 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            pc         <= RESET_PC;
            ifid_valid <= 1'b0;
            ifid_instr <= 32'h0;
            ifid_pc4   <= 32'h0;
            fetch_err  <= 1'b0;
            skid_instr <= 32'h0;
            skid_pc4   <= 32'h0;
            skid_valid <= 1'b0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            ifid_valid <= ifid_valid_nxt;
            ifid_instr <= ifid_instr_nxt;
            ifid_pc4   <= ifid_pc4_nxt;
            fetch_err  <= fetch_err_nxt;
            skid_instr <= skid_instr_nxt;
            skid_pc4   <= skid_pc4_nxt;
            skid_valid <= skid_valid_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        ifid_valid_nxt = ifid_valid;
        ifid_instr_nxt = ifid_instr;
        ifid_pc4_nxt   = ifid_pc4;
        fetch_err_nxt  = fetch_err;
        skid_instr_nxt = skid_instr;
        skid_pc4_nxt   = skid_pc4;
        skid_valid_nxt = skid_valid;

        if (redir_active) begin
            // Redirect beats stall and ack; any word returned this cycle is dropped.
            ifid_valid_nxt = 1'b0;
            skid_valid_nxt = 1'b0;
            if (redir_misaligned) begin
                state_nxt     = S_ERR;
                fetch_err_nxt = 1'b1;
            end else begin
                state_nxt = S_FETCH;
                pc_nxt    = redirect_pc;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    state_nxt = S_FETCH;
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        if (!stall) begin
                            ifid_instr_nxt = imem_rdata;
                            ifid_pc4_nxt   = pc_plus4;
                            ifid_valid_nxt = 1'b1;
                            pc_nxt         = pc_plus4;
                        end else begin
                            skid_instr_nxt = imem_rdata;
                            skid_pc4_nxt   = pc_plus4;
                            skid_valid_nxt = 1'b1;
                            state_nxt      = S_HOLD;
                        end
                    end else if (!stall) begin
                        ifid_valid_nxt = 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        if (skid_valid) begin
                            ifid_instr_nxt = skid_instr;
                            ifid_pc4_nxt   = skid_pc4;
                            ifid_valid_nxt = 1'b1;
                            pc_nxt         = skid_pc4;
                        end
                        skid_valid_nxt = 1'b0;
                        state_nxt      = S_FETCH;
                    end
                end
                default: begin
                    state_nxt = S_ERR;
                end
            endcase
        end
    end

endmodule
